// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared types and constants for the Genius round controller
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHOW    = 3'd1,
    ST_GAP     = 3'd2,
    ST_WAIT_IN = 3'd3,
    ST_RELEASE = 3'd4,
    ST_WIN     = 3'd5,
    ST_LOSE    = 3'd6
  } state_e;

  localparam logic [1:0] SYM_0    = 2'd0;
  localparam logic [1:0] SYM_1    = 2'd1;
  localparam logic [1:0] SYM_2    = 2'd2;
  localparam logic [1:0] SYM_NONE = 2'd3;

  localparam int DEF_SEQ_LEN       = 16;
  localparam int DEF_SHOW_TICKS    = 4;
  localparam int DEF_GAP_TICKS     = 2;
  localparam int DEF_TIMEOUT_TICKS = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/genius_press_detect.sv
// rtl/genius_press_detect.sv - button edge detect and symbol encode
// A press is the first cycle any button is seen after all buttons were released.
module genius_press_detect
  import genius_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] btn_i,
  output logic       press_o,
  output logic       onehot_o,
  output logic [1:0] sym_o
);

  logic [2:0] prev_btn_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_btn_q <= 3'b000;
    end else begin
      prev_btn_q <= btn_i;
    end
  end

  always_comb begin
    press_o  = (prev_btn_q == 3'b000) && (btn_i != 3'b000);
    onehot_o = 1'b0;
    sym_o    = SYM_NONE;
    case (btn_i)
      3'b001: begin onehot_o = 1'b1; sym_o = SYM_0; end
      3'b010: begin onehot_o = 1'b1; sym_o = SYM_1; end
      3'b100: begin onehot_o = 1'b1; sym_o = SYM_2; end
      default: begin onehot_o = 1'b0; sym_o = SYM_NONE; end
    endcase
  end

endmodule

// File: rtl/genius_round_ctrl.sv
// rtl/genius_round_ctrl.sv - Genius round sequencer: show pattern, collect presses, grow level
// Outputs decode from state registers; seq_sym_i -> show_sym_o is the only combinational path.
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int SEQ_LEN       = DEF_SEQ_LEN,
  parameter int SHOW_TICKS    = DEF_SHOW_TICKS,
  parameter int GAP_TICKS     = DEF_GAP_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [2:0]                   btn_i,
  output logic [$clog2(SEQ_LEN)-1:0]   seq_idx_o,
  input  logic [1:0]                   seq_sym_i,
  output logic                         show_valid_o,
  output logic [1:0]                   show_sym_o,
  output logic [$clog2(SEQ_LEN+1)-1:0] level_o,
  output logic                         in_phase_o,
  output logic                         win_o,
  output logic                         lose_o
);

  localparam int IW    = $clog2(SEQ_LEN);
  localparam int LW    = $clog2(SEQ_LEN + 1);
  localparam int TMAX  = max3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS);
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(SEQ_LEN);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] level_q, level_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       press;
  logic       onehot;
  logic [1:0] btn_sym;
  logic       last_idx;

  genius_press_detect u_press (
    .clk_i    (clock_i),
    .reset_i  (reset_i),
    .btn_i    (btn_i),
    .press_o  (press),
    .onehot_o (onehot),
    .sym_o    (btn_sym)
  );

  assign last_idx = (LW'(idx_q) == (level_q - LW'(1)));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      level_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    level_d = level_q;
    timer_d = '0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start_i) begin
          state_d = ST_SHOW;
          level_d = LW'(1);
          idx_d   = '0;
        end
      end
      ST_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          if (last_idx) begin
            state_d = ST_WAIT_IN;
            idx_d   = '0;
          end else begin
            state_d = ST_SHOW;
            idx_d   = idx_q + IW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_IN: begin
        // A press outranks a timeout landing in the same cycle.
        if (press) begin
          state_d = (onehot && (btn_sym == seq_sym_i)) ? ST_RELEASE : ST_LOSE;
        end else if (timer_q == TO_LAST) begin
          state_d = ST_LOSE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RELEASE: begin
        if (btn_i == 3'b000) begin
          if (!last_idx) begin
            state_d = ST_WAIT_IN;
            idx_d   = idx_q + IW'(1);
          end else if (level_q == LEVEL_MAX) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_SHOW;
            level_d = level_q + LW'(1);
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        level_d = '0;
      end
    endcase
  end

  assign seq_idx_o    = idx_q;
  assign level_o      = level_q;
  assign show_valid_o = (state_q == ST_SHOW);
  assign show_sym_o   = show_valid_o ? seq_sym_i : SYM_0;
  assign in_phase_o   = (state_q == ST_WAIT_IN) || (state_q == ST_RELEASE);
  assign win_o        = (state_q == ST_WIN);
  assign lose_o       = (state_q == ST_LOSE);

endmodule

// File: tb/tb_genius_round_ctrl.sv
// tb/tb_genius_round_ctrl.sv - directed self-checking bench for genius_round_ctrl (SEQ_LEN=4)
module tb_genius_round_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] btn;
  logic [1:0] seq_idx;
  logic [1:0] seq_sym;
  logic       show_valid;
  logic [1:0] show_sym;
  logic [2:0] level;
  logic       in_phase;
  logic       win;
  logic       lose;

  int checks   = 0;
  int failures = 0;

  logic [1:0] seq_mem [4];

  assign seq_sym = seq_mem[seq_idx];

  genius_round_ctrl #(
    .SEQ_LEN       (4),
    .SHOW_TICKS    (4),
    .GAP_TICKS     (2),
    .TIMEOUT_TICKS (64)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .start_i      (start),
    .btn_i        (btn),
    .seq_idx_o    (seq_idx),
    .seq_sym_i    (seq_sym),
    .show_valid_o (show_valid),
    .show_sym_o   (show_sym),
    .level_o      (level),
    .in_phase_o   (in_phase),
    .win_o        (win),
    .lose_o       (lose)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".show_valid"}, 32'(show_valid), 32'd0);
    chk({tag, ".show_sym"},   32'(show_sym),   32'd0);
    chk({tag, ".level"},      32'(level),      32'd0);
    chk({tag, ".seq_idx"},    32'(seq_idx),    32'd0);
    chk({tag, ".in_phase"},   32'(in_phase),   32'd0);
    chk({tag, ".win"},        32'(win),        32'd0);
    chk({tag, ".lose"},       32'(lose),       32'd0);
  endtask

  // Entered in the first SHOW cycle of a round; leaves in the first WAIT_IN cycle.
  task automatic show_round(input int lvl);
    for (int k = 0; k < lvl; k++) begin
      for (int t = 0; t < 4; t++) begin
        chk("show.valid", 32'(show_valid), 32'd1);
        chk("show.sym",   32'(show_sym),   32'(seq_mem[k]));
        chk("show.level", 32'(level),      32'(lvl));
        cycle();
      end
      for (int t = 0; t < 2; t++) begin
        chk("gap.valid", 32'(show_valid), 32'd0);
        chk("gap.sym",   32'(show_sym),   32'd0);
        cycle();
      end
    end
    chk("wait.in_phase", 32'(in_phase), 32'd1);
    chk("wait.idx",      32'(seq_idx),  32'd0);
    chk("wait.level",    32'(level),    32'(lvl));
  endtask

  task automatic play_round(input int lvl);
    show_round(lvl);
    for (int k = 0; k < lvl; k++) begin
      btn = 3'(1 << seq_mem[k]);
      cycle();
      chk("rel.in_phase", 32'(in_phase), 32'd1);
      cycle();
      chk("rel.hold", 32'(in_phase), 32'd1);
      chk("rel.idx",  32'(seq_idx),  32'(k));
      btn = 3'b000;
      cycle();
    end
    if (lvl < 4) begin
      chk("next.level", 32'(level),      32'(lvl + 1));
      chk("next.show",  32'(show_valid), 32'd1);
    end
  endtask

  initial begin
    seq_mem[0] = 2'd2;
    seq_mem[1] = 2'd1;
    seq_mem[2] = 2'd0;
    seq_mem[3] = 2'd2;
    reset = 1'b1;
    start = 1'b0;
    btn   = 3'b000;
    cycle();
    cycle();
    reset = 1'b0;
    chk_idle_outputs("reset");

    // First round, then a correct press advances to level 2.
    start = 1'b1;
    cycle();
    start = 1'b0;
    show_round(1);
    btn = 3'b100;
    cycle();
    chk("r1.release", 32'(in_phase), 32'd1);
    chk("r1.lose",    32'(lose),     32'd0);
    btn = 3'b000;
    cycle();
    chk("r2.level", 32'(level),      32'd2);
    chk("r2.show",  32'(show_valid), 32'd1);
    show_round(2);

    // Wrong button at level 2 (expecting symbol 2).
    btn = 3'b010;
    cycle();
    chk("wrong.lose",  32'(lose),     32'd1);
    chk("wrong.level", 32'(level),    32'd2);
    chk("wrong.phase", 32'(in_phase), 32'd0);
    btn = 3'b000;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart.lose",  32'(lose),       32'd0);
    chk("restart.level", 32'(level),      32'd1);
    chk("restart.show",  32'(show_valid), 32'd1);

    // Button held across WAIT_IN entry never counts; timeout after 64 cycles.
    btn = 3'b001;
    show_round(1);
    repeat (63) cycle();
    chk("hold.not_yet", 32'(lose),     32'd0);
    chk("hold.phase",   32'(in_phase), 32'd1);
    cycle();
    chk("hold.timeout", 32'(lose), 32'd1);
    btn = 3'b000;

    // Two buttons at once.
    start = 1'b1;
    cycle();
    start = 1'b0;
    show_round(1);
    btn = 3'b011;
    cycle();
    chk("multi.lose", 32'(lose), 32'd1);
    btn = 3'b000;

    // Reset in the middle of SHOW.
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    chk("mid.show", 32'(show_valid), 32'd1);
    reset = 1'b1;
    cycle();
    chk_idle_outputs("midreset");
    start = 1'b1;
    cycle();
    chk_idle_outputs("reset_and_start");
    reset = 1'b0;
    start = 1'b0;
    cycle();
    chk("idle.stays", 32'(show_valid), 32'd0);

    // Full game to a win; start during play is ignored.
    start = 1'b1;
    cycle();
    start = 1'b0;
    show_round(1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("ign.phase", 32'(in_phase), 32'd1);
    chk("ign.level", 32'(level),    32'd1);
    btn = 3'b100;
    cycle();
    btn = 3'b000;
    cycle();
    chk("ign.level2", 32'(level), 32'd2);
    play_round(2);
    play_round(3);
    play_round(4);
    chk("win.flag",  32'(win),      32'd1);
    chk("win.level", 32'(level),    32'd4);
    chk("win.phase", 32'(in_phase), 32'd0);
    cycle();
    chk("win.held", 32'(win), 32'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("win.restart",  32'(win),        32'd0);
    chk("win.level1",   32'(level),      32'd1);
    chk("win.show",     32'(show_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
